// File: rtl/freecell_pkg.sv
// freecell_pkg: shared locations, card layout, helpers and FSM states for the FreeCell engine
package freecell_pkg;

   typedef enum logic [3:0] {
      COL0, COL1, COL2, COL3, COL4, COL5, COL6, COL7,
      CELL_A, CELL_B, CELL_C, CELL_D, HOME
   } loc_e;

   localparam logic [3:0] RANK_EMPTY = 4'd0;
   localparam logic [3:0] RANK_KING  = 4'd13;

   typedef struct packed {
      logic [1:0] suit;
      logic [3:0] rank;
   } card_t;

   typedef enum logic [1:0] {LOAD, PLAY, WON} state_e;

   function automatic logic is_home(input logic [3:0] loc);
      return loc[3:2] == 2'b11;
   endfunction

   function automatic logic is_cell(input logic [3:0] loc);
      return loc[3:2] == 2'b10;
   endfunction

   function automatic logic is_red(input logic [1:0] suit);
      return suit[0] ^ suit[1];
   endfunction

endpackage

// File: rtl/freecell_move_check.sv
// freecell_move_check: combinational FreeCell legality test for one single-card move
module freecell_move_check
   import freecell_pkg::*;
#(
   parameter int MAX_DEPTH = 20,
   parameter int DW        = 5
) (
   input  card_t           src_card_i,
   input  card_t           dst_card_i,
   input  logic [3:0]      home_rank_i,
   input  logic [DW-1:0]   dst_depth_i,
   input  logic            src_home_i,
   input  logic            dst_home_i,
   input  logic            dst_cell_i,
   input  logic            same_i,
   input  logic            unknown_i,
   output logic            legal_o
);

   logic col_ok;

   // A non-home, non-cell destination is a column: full rejects, empty accepts, else alternate colour descending
   always_comb begin
      col_ok  = (dst_depth_i == DW'(MAX_DEPTH)) ? 1'b0 :
                (dst_depth_i == '0) ? 1'b1 :
                (is_red(dst_card_i.suit) != is_red(src_card_i.suit)) &&
                (dst_card_i.rank == src_card_i.rank + 4'd1);
      legal_o = 1'b0;
      if (!(src_home_i || same_i || unknown_i || src_card_i.rank == RANK_EMPTY))
         legal_o = dst_home_i ? (src_card_i.rank == home_rank_i + 4'd1) :
                   dst_cell_i ? (dst_card_i.rank == RANK_EMPTY) : col_ok;
   end

endmodule

// File: rtl/freecell_player.sv
// freecell_player: FreeCell game state, move application, win detection and move counting
module freecell_player
   import freecell_pkg::*;
#(
   parameter int MAX_DEPTH = 20,
   parameter int CNT_W     = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic [3:0]       source,
   input  logic [3:0]       dest,
   input  logic             deal_we,
   input  logic [2:0]       deal_col,
   input  logic [5:0]       deal_card,
   input  logic             deal_done,
   output logic             win,
   output logic             move_ok,
   output logic             illegal,
   output logic [CNT_W-1:0] move_count
);

   localparam int DW = $clog2(MAX_DEPTH + 1);
   localparam int IW = $clog2(MAX_DEPTH);

   card_t            col_q [8][MAX_DEPTH];
   logic [DW-1:0]    depth_q [8];
   card_t            cell_q [4];
   logic [3:0]       home_q [4];
   state_e           state_q, state_d;
   logic             win_q, win_d, move_ok_q, move_ok_d, illegal_q, illegal_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   card_t            top [8];
   card_t            src_card, dst_card;
   logic             legal, play, apply, won, push;

   // Top card of each column, empty card when the column has no cards
   always_comb begin
      for (int c = 0; c < 8; c++)
         top[c] = (depth_q[c] == '0) ? card_t'('0) : col_q[c][IW'(depth_q[c] - DW'(1))];
   end

   assign src_card = source[3] ? cell_q[source[1:0]] : top[source[2:0]];
   assign dst_card = dest[3] ? cell_q[dest[1:0]] : top[dest[2:0]];
   assign play     = state_q == PLAY;
   assign apply    = play && legal;
   assign push     = state_q == LOAD && deal_we && depth_q[deal_col] != DW'(MAX_DEPTH);

   freecell_move_check #(.MAX_DEPTH(MAX_DEPTH), .DW(DW)) u_check (
      .src_card_i  (src_card),
      .dst_card_i  (dst_card),
      .home_rank_i (home_q[src_card.suit]),
      .dst_depth_i (depth_q[dest[2:0]]),
      .src_home_i  (is_home(source)),
      .dst_home_i  (is_home(dest)),
      .dst_cell_i  (is_cell(dest)),
      .same_i      (source == dest),
      .unknown_i   ($isunknown({source, dest})),
      .legal_o     (legal)
   );

   // A legal king going home wins when the other three suits are already complete
   always_comb begin
      won = apply && is_home(dest) && src_card.rank == RANK_KING;
      for (int s = 0; s < 4; s++)
         if (2'(s) != src_card.suit && home_q[s] != RANK_KING) won = 1'b0;
   end

   // Next state and next values of the registered outputs
   always_comb begin
      state_d   = state_q;
      move_ok_d = apply;
      illegal_d = play && !legal;
      cnt_d     = cnt_q + CNT_W'(apply && !(&cnt_q));
      win_d     = win_q || won;
      if (state_q == LOAD && deal_done) state_d = PLAY;
      if (won) state_d = WON;
   end

   // FSM state and output registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= LOAD;
         win_q     <= 1'b0;
         move_ok_q <= 1'b0;
         illegal_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         win_q     <= win_d;
         move_ok_q <= move_ok_d;
         illegal_q <= illegal_d;
         cnt_q     <= cnt_d;
      end
   end

   // Column depths, free cells and home ranks: grow on deal pushes, move a card on each legal move
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int c = 0; c < 8; c++) depth_q[c] <= '0;
         for (int i = 0; i < 4; i++) begin
            cell_q[i] <= '0;
            home_q[i] <= RANK_EMPTY;
         end
      end else if (push) begin
         depth_q[deal_col] <= depth_q[deal_col] + DW'(1);
      end else if (apply) begin
         if (source[3]) cell_q[source[1:0]] <= '0;
         else depth_q[source[2:0]] <= depth_q[source[2:0]] - DW'(1);
         if (is_home(dest)) home_q[src_card.suit] <= home_q[src_card.suit] + 4'd1;
         else if (dest[3]) cell_q[dest[1:0]] <= src_card;
         else depth_q[dest[2:0]] <= depth_q[dest[2:0]] + DW'(1);
      end
   end

   // Column card storage; only the slot just above the current top is ever written
   always_ff @(posedge clock) begin
      if (push) col_q[deal_col][IW'(depth_q[deal_col])] <= card_t'(deal_card);
      else if (apply && !dest[3]) col_q[dest[2:0]][IW'(depth_q[dest[2:0]])] <= src_card;
   end

   assign win        = win_q;
   assign move_ok    = move_ok_q;
   assign illegal    = illegal_q;
   assign move_count = cnt_q;

endmodule

// File: tb/tb_freecell_player.sv
// tb_freecell_player: scoreboard bench driving deals and moves, monitor checks every output cycle
module tb_freecell_player;

   typedef struct {
      logic       ok;
      logic       ill;
      logic [7:0] cnt;
      logic       w;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset_n;
   logic [3:0] source, dest;
   logic       deal_we, deal_done;
   logic [2:0] deal_col;
   logic [5:0] deal_card;
   logic       win, move_ok, illegal;
   logic [7:0] move_count;

   exp_t       q[$];
   int         asserts = 0;
   int         fails = 0;
   int         exp_cnt = 0;

   freecell_player #(.MAX_DEPTH(20), .CNT_W(8)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .source     (source),
      .dest       (dest),
      .deal_we    (deal_we),
      .deal_col   (deal_col),
      .deal_card  (deal_card),
      .deal_done  (deal_done),
      .win        (win),
      .move_ok    (move_ok),
      .illegal    (illegal),
      .move_count (move_count)
   );

   always #5 clock = ~clock;

   function automatic void chk(input string n, input logic [31:0] a, input logic [31:0] e);
      asserts++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endfunction

   task automatic deal(input int c, input logic [5:0] card);
      @(negedge clock);
      deal_we   = 1'b1;
      deal_col  = 3'(c);
      deal_card = card;
   endtask

   task automatic done();
      @(negedge clock);
      deal_we   = 1'b0;
      deal_done = 1'b1;
   endtask

   task automatic mv(input int s, input int d, input logic ok, input logic ill, input logic w);
      exp_t e;
      @(negedge clock);
      deal_done = 1'b0;
      deal_we   = 1'b0;
      source    = 4'(s);
      dest      = 4'(d);
      if (ok && exp_cnt < 255) exp_cnt++;
      e.ok  = ok;
      e.ill = ill;
      e.cnt = 8'(exp_cnt);
      e.w   = w;
      q.push_back(e);
   endtask

   task automatic rst();
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      chk("rst_win", win, 0);
      chk("rst_count", move_count, 0);
      chk("rst_pulses", {move_ok, illegal}, 0);
      @(negedge clock);
      reset_n = 1'b1;
      exp_cnt = 0;
   endtask

   // Each pushed expectation is answered by the edge right after it; with nothing queued no pulse may appear
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("pulses", {move_ok, illegal}, {e.ok, e.ill});
            chk("count", move_count, e.cnt);
            chk("win", win, e.w);
         end else begin
            chk("idle_pulses", {move_ok, illegal}, 0);
         end
      end
   end

   initial begin
      reset_n   = 1'b0;
      deal_we   = 1'b0;
      deal_done = 1'b0;
      deal_col  = 3'd0;
      deal_card = 6'd0;
      source    = 4'd0;
      dest      = 4'd0;
      #1;
      chk("reset_win", win, 0);
      chk("reset_ok", move_ok, 0);
      chk("reset_ill", illegal, 0);
      chk("reset_count", move_count, 0);
      @(negedge clock);
      reset_n = 1'b1;

      deal(0, 6'h01);
      deal(1, 6'h0D);
      deal(1, 6'h27);
      deal(2, 6'h38);
      deal(3, 6'h19);
      deal(4, 6'h28);
      for (int i = 0; i < 19; i++) deal(5, 6'h31);
      deal(5, 6'h08);
      deal(5, 6'h22);
      for (int r = 2; r <= 5; r++) deal(6, 6'(8'h30 + r));
      done();

      mv(0, 12, 1, 0, 0);
      mv(0, 12, 0, 1, 0);
      mv(12, 3, 0, 1, 0);
      mv(1, 2, 1, 0, 0);
      mv(2, 1, 0, 1, 0);
      mv(2, 5, 0, 1, 0);
      mv(4, 3, 0, 1, 0);
      mv(5, 3, 1, 0, 0);
      for (int c = 8; c < 12; c++) mv(6, c, 1, 0, 0);
      mv(4, 8, 0, 1, 0);
      mv(6, 0, 0, 1, 0);
      mv(8, 7, 1, 0, 0);
      mv(4, 8, 1, 0, 0);
      mv(3, 3, 0, 1, 0);
      mv(7, 12, 0, 1, 0);

      rst();
      for (int s = 0; s < 4; s++)
         for (int r = 13; r >= 1; r--) deal(s, 6'((s << 4) | r));
      done();
      for (int r = 1; r <= 13; r++)
         for (int s = 0; s < 4; s++) mv(s, 12 + s, 1, 0, (r == 13 && s == 3));
      mv(0, 12, 0, 0, 1);
      mv(4, 8, 0, 0, 1);

      rst();
      mv(0, 12, 0, 0, 0);
      done();
      mv(0, 12, 0, 1, 0);

      @(negedge clock);
      chk("queue_drained", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule

// File: doc/freecell_player.md
Name: freecell_player

Overview:
- Game engine at the receiving end of the FreeCell move interface.
- Holds the full game state: 8 tableau columns, 4 free cells and 4 home foundations.
- Accepts one (source, dest) move per clock, checks it against FreeCell rules, and applies it if legal; illegal moves are rejected with no state change.
- Asserts win once all 52 cards are home. The initial deal is loaded through a card-push port before play starts.

Parameters:
- MAX_DEPTH, 20, maximum cards per tableau column (19 is the worst case in real play).
- CNT_W, 8, width of the legal-move counter.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- source  in  4  move source: 0-7 tableau column 1-8; 8-11 free cell a-d; 12-15 home.
- dest  in  4  move destination, same encoding; 12-15 all mean home, the two LSBs are ignored.
- deal_we  in  1  push deal_card onto column deal_col this cycle (LOAD state only).
- deal_col  in  3  target column for the deal push.
- deal_card  in  6  {suit[1:0], rank[3:0]}; suits 0=clubs, 1=diamonds, 2=hearts, 3=spades; rank 1-13.
- deal_done  in  1  one-cycle pulse that ends LOAD.
- win  out  1  registered, sticky until reset.
- move_ok  out  1  registered pulse: the previous-cycle move was legal and applied.
- illegal  out  1  registered pulse: the previous-cycle move was rejected.
- move_count  out  CNT_W  number of legal moves applied; saturates at all-ones.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - all columns empty, free cells empty, home ranks 0;
  - state LOAD;
  - win=0, move_ok=0, illegal=0, move_count=0.
- FSM states: LOAD, PLAY, WON.
  - LOAD -> PLAY on deal_done.
  - PLAY -> WON on the edge where a legal move makes all four home ranks 13.
  - WON is held until reset.
- LOAD state:
  - deal_we=1 pushes deal_card onto the top of column deal_col.
  - A push to a full column is dropped.
  - source and dest are ignored; move_ok and illegal stay 0.
- PLAY state, source and dest sampled every posedge:
  - Source card: top of a column, or free-cell contents.
  - The move is illegal if the source is home, the source is empty, source equals dest, or either code is X/unknown.
  - dest home: legal iff source rank equals home[suit]+1. Home[suit] then increments and the card is removed from the source.
  - dest free cell: legal iff that cell is empty. Cell-to-cell moves are allowed.
  - dest column, empty: any card is legal.
  - dest column, non-empty: legal iff the top card has the opposite colour and rank = source rank + 1. Red is suit[0]^suit[1].
  - dest column at MAX_DEPTH: illegal.
  - Only single-card moves exist; there are no supermoves.
- Latency, for a move sampled at edge N:
  - state is updated at edge N;
  - move_ok or illegal is high for the cycle after edge N;
  - move_count reflects the move after edge N;
  - win rises at the same edge N that places the last king.
- Pulses: move_ok and illegal are mutually exclusive, and exactly one of them pulses per PLAY cycle.
- WON state: moves are ignored, move_ok and illegal stay 0, and win stays 1.
- Reset mid-game returns to LOAD immediately with all state cleared.
- deal_we or deal_done in PLAY or WON: ignored.
- move_count: increments on each legal move and holds at all-ones.

Decomposition:
- freecell_pkg holds:
  - location constants: COL0..COL7=0..7, CELL_A..CELL_D=8..11, HOME=12, plus an is_home(loc) test on bits [3:2]==2'b11;
  - card field slices, RANK_EMPTY=0, RANK_KING=13;
  - function is_red(suit);
  - the FSM state enum.
- Sub-module freecell_move_check, purely combinational:
  - inputs: source card, dest top card or cell/home occupancy, dest depth, decoded location classes;
  - output: legal.
- The top level owns the column RAM/regs, depth counters, free cells, home ranks, the FSM and the output registers.

Test Plan:
- Reset, deal clubs A onto column 1 (deal_col=0), deal_done, then move "1h" (source=0, dest=12) -> move_ok=1 next cycle, home[clubs]=1, move_count=1, column 1 empty.
- Move "1h" again with column 1 empty -> illegal=1, move_count unchanged.
- Move "h4" (source=12) -> illegal=1.
- Column 2 top is hearts 7, column 3 top is spades 8; move "23" -> legal and column 3 depth +1. Reverse move "32" -> illegal (rank mismatch). Clubs 8 onto diamonds 9 -> legal; hearts 8 onto diamonds 9 -> illegal (same colour).
- Fill free cells a-d, then "5a" -> illegal. Then "a8" onto an empty column 8 -> legal, and cell a is empty afterwards.
- Load a deal in which all 52 cards are stacked so that 52 "Xh" moves solve it -> win rises on the edge of the 52nd move, move_count=52. A further move gives neither pulse. Asserting reset_n=0 mid-game clears win and move_count asynchronously and the block returns to LOAD.
